// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VESA-style video timing generator with pixel enable,
//            programmable sync polarity and a wrapping frame counter.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CNT_W     = 11,
    parameter int FRM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic [FRM_W-1:0] frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             c_HS_ON    = (HSYNC_POL != 0);
    localparam logic             c_VS_ON    = (VSYNC_POL != 0);

    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
        (c_H_TOTAL > (2 ** CNT_W)) || (c_V_TOTAL > (2 ** CNT_W))) begin : g_param_check
        $error("vga_timing_gen: zero porch/sync width or totals exceed CNT_W range");
    end

    logic [CNT_W-1:0] r_hcount, r_vcount;
    logic [FRM_W-1:0] r_frame_cnt;
    logic             r_hsync, r_vsync, r_hblnk, r_vblnk, r_de;
    logic             r_line_start, r_frame_start;

    logic             w_h_last, w_v_last;
    logic [CNT_W-1:0] w_nh, w_nv;
    logic [FRM_W-1:0] w_nfrm;

    // Next-position logic; reset forces (0,0) so the flag decode below also
    // yields the reset values of every output.
    always_comb begin
        w_h_last = (r_hcount == c_H_LAST);
        w_v_last = (r_vcount == c_V_LAST);
        w_nh     = r_hcount + CNT_W'(1);
        w_nv     = r_vcount;
        w_nfrm   = r_frame_cnt;
        if (w_h_last) begin
            w_nh = '0;
            w_nv = w_v_last ? '0 : r_vcount + CNT_W'(1);
            if (w_v_last) begin
                w_nfrm = r_frame_cnt + FRM_W'(1);
            end
        end
        if (rst) begin
            w_nh   = '0;
            w_nv   = '0;
            w_nfrm = '0;
        end
    end

    // Flags are decoded from the next counts so they line up with hcount/vcount.
    always_ff @(posedge clk) begin
        if (rst || en) begin
            r_hcount      <= w_nh;
            r_vcount      <= w_nv;
            r_frame_cnt   <= w_nfrm;
            r_hblnk       <= (w_nh >= c_H_ACT);
            r_vblnk       <= (w_nv >= c_V_ACT);
            r_de          <= (w_nh < c_H_ACT) && (w_nv < c_V_ACT);
            r_hsync       <= ((w_nh >= c_HS_BEG) && (w_nh <= c_HS_END)) ? c_HS_ON : ~c_HS_ON;
            r_vsync       <= ((w_nv >= c_VS_BEG) && (w_nv <= c_VS_END)) ? c_VS_ON : ~c_VS_ON;
            r_line_start  <= (w_nh == '0);
            r_frame_start <= (w_nh == '0) && (w_nv == '0);
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign frame_cnt   = r_frame_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench: default XGA instance for line
//            timing, small instance for frame, enable and reset behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst, d_en;
    logic [10:0] d_hcount, d_vcount;
    logic        d_hsync, d_vsync, d_hblnk, d_vblnk, d_de, d_line_start, d_frame_start;
    logic [7:0]  d_frame_cnt;

    logic        s_rst, s_en;
    logic [10:0] s_hcount, s_vcount;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_de, s_line_start, s_frame_start;
    logic [1:0]  s_frame_cnt;
    logic [30:0] s_snap;

    assign s_snap = {s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk,
                     s_de, s_line_start, s_frame_start, s_frame_cnt};

    vga_timing_gen u_dut_xga (
        .clk(clk), .rst(d_rst), .en(d_en),
        .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
        .hblnk(d_hblnk), .vblnk(d_vblnk), .de(d_de), .line_start(d_line_start),
        .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .FRM_W(2)
    ) u_dut_small (
        .clk(clk), .rst(s_rst), .en(s_en),
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .hblnk(s_hblnk), .vblnk(s_vblnk), .de(s_de), .line_start(s_line_start),
        .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hb_rise, hb_fall, hs_first, hs_last, hs_len, ls_cnt, ls_a, ls_b, hmax, vmax, de_err;
    int hs_err, vs_err, vb_err, hb_err, de_cnt, hs_hi, fs_k, frz_err;
    int fc [4];
    logic p_hblnk, p_en;
    logic [30:0] p_snap;
    logic [10:0] p_h, p_v;

    initial begin
        d_rst = 1'b1; d_en = 1'b1; s_rst = 1'b1; s_en = 1'b1;
        repeat (3) tick();

        // reset state, default instance (active-low syncs idle high)
        check("rst_hcount", d_hcount, 0);
        check("rst_vcount", d_vcount, 0);
        check("rst_hsync", d_hsync, 1);
        check("rst_vsync", d_vsync, 1);
        check("rst_hblnk", d_hblnk, 0);
        check("rst_vblnk", d_vblnk, 0);
        check("rst_de", d_de, 1);
        check("rst_line_start", d_line_start, 1);
        check("rst_frame_start", d_frame_start, 1);
        check("rst_frame_cnt", d_frame_cnt, 0);
        check("rst_small_hsync", s_hsync, 0);
        check("rst_small_vsync", s_vsync, 0);

        d_rst = 1'b0; s_en = 1'b0;
        tick();
        check("first_hcount", d_hcount, 1);
        check("first_frame_start", d_frame_start, 0);
        check("first_line_start", d_line_start, 0);

        // two full lines on the default instance
        hb_rise = -1; hb_fall = -1; hs_first = -1; hs_last = -1; hs_len = 0;
        ls_cnt = 0; ls_a = 0; ls_b = 0; hmax = 0; de_err = 0;
        p_hblnk = d_hblnk;
        for (int c = 0; c < 2688; c++) begin
            tick();
            if (d_hblnk && !p_hblnk && hb_rise < 0) hb_rise = int'(d_hcount);
            if (!d_hblnk && p_hblnk && hb_fall < 0) hb_fall = int'(d_hcount);
            p_hblnk = d_hblnk;
            if (d_vcount == 11'd0 && !d_hsync) begin
                if (hs_first < 0) hs_first = int'(d_hcount);
                hs_last = int'(d_hcount);
                hs_len++;
            end
            if (d_line_start) begin
                if (ls_cnt == 0) ls_a = c; else ls_b = c;
                ls_cnt++;
            end
            if (int'(d_hcount) > hmax) hmax = int'(d_hcount);
            if (d_de !== ((d_hcount < 11'd1024) && (d_vcount < 11'd768))) de_err++;
        end
        check("hblnk_rise_at", hb_rise, 1024);
        check("hblnk_fall_at", hb_fall, 0);
        check("hsync_first", hs_first, 1048);
        check("hsync_last", hs_last, 1183);
        check("hsync_len", hs_len, 136);
        check("line_start_cnt", ls_cnt, 2);
        check("line_period", ls_b - ls_a, 1344);
        check("hcount_max", hmax, 1343);
        check("de_decode_err", de_err, 0);
        check("after2_hcount", d_hcount, 1);
        check("after2_vcount", d_vcount, 2);

        // small instance, en=1, four frames
        s_en = 1'b1;
        tick();
        s_rst = 1'b0;
        hs_err = 0; vs_err = 0; vb_err = 0; hb_err = 0; de_cnt = 0; hs_hi = 0;
        hmax = 0; vmax = 0; fs_k = 0;
        p_h = s_hcount; p_v = s_vcount;
        for (int c = 0; c < 392; c++) begin
            tick();
            if (s_hsync !== ((s_hcount >= 11'd10) && (s_hcount <= 11'd11))) hs_err++;
            if (s_vsync !== (s_vcount == 11'd5)) vs_err++;
            if (s_vblnk !== (s_vcount >= 11'd4)) vb_err++;
            if (s_hblnk !== (s_hcount >= 11'd8)) hb_err++;
            if (c < 98 && s_de) de_cnt++;
            if (c < 98 && s_hsync) hs_hi++;
            if (int'(s_hcount) > hmax) hmax = int'(s_hcount);
            if (int'(s_vcount) > vmax) vmax = int'(s_vcount);
            if (p_h == 11'd13 && p_v == 11'd6)
                check("wrap_to_origin", {s_hcount, s_vcount, s_frame_start}, 23'd1);
            if (s_frame_start && fs_k < 4) begin
                fc[fs_k] = int'(s_frame_cnt);
                fs_k++;
            end
            p_h = s_hcount; p_v = s_vcount;
        end
        check("small_hsync_err", hs_err, 0);
        check("small_vsync_err", vs_err, 0);
        check("small_vblnk_err", vb_err, 0);
        check("small_hblnk_err", hb_err, 0);
        check("small_de_per_frame", de_cnt, 32);
        check("small_hsync_hi", hs_hi, 14);
        check("small_hmax", hmax, 13);
        check("small_vmax", vmax, 6);
        check("frame_starts", fs_k, 4);
        check("frame_cnt_0", fc[0], 1);
        check("frame_cnt_1", fc[1], 2);
        check("frame_cnt_2", fc[2], 3);
        check("frame_cnt_3", fc[3], 0);

        // divide-by-3 enable: one frame in 3*98 clocks, frozen otherwise
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        frz_err = 0;
        p_snap = s_snap;
        for (int c = 0; c < 294; c++) begin
            s_en = (c % 3 == 0);
            p_en = s_en;
            tick();
            if (!p_en && s_snap !== p_snap) frz_err++;
            if (c == 1) check("div3_step1", s_hcount, 1);
            p_snap = s_snap;
        end
        check("div3_freeze_err", frz_err, 0);
        check("div3_hcount", s_hcount, 0);
        check("div3_vcount", s_vcount, 0);
        check("div3_frame_cnt", s_frame_cnt, 1);
        check("div3_frame_start", s_frame_start, 1);

        // mid-frame reset, asserted while en=0
        s_en = 1'b1;
        repeat (33) tick();
        check("pre_rst_pos", {s_hcount, s_vcount}, {11'd5, 11'd2});
        s_rst = 1'b1; s_en = 1'b0;
        tick();
        check("mid_rst_hcount", s_hcount, 0);
        check("mid_rst_vcount", s_vcount, 0);
        check("mid_rst_frame_cnt", s_frame_cnt, 0);
        check("mid_rst_syncs", {s_hsync, s_vsync}, 0);
        check("mid_rst_strobes", {s_line_start, s_frame_start, s_de}, 3'b111);
        s_rst = 1'b0; s_en = 1'b1;
        tick();
        check("post_rst_hcount", s_hcount, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
